// File: rtl/plus_mult_seq_pkg.sv
// rtl/plus_mult_seq_pkg.sv - shared constants and FSM state type for the repeated-add multiplier
package plus_mult_seq_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ACC_W_DEF  = 2 * DATA_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/plus_mult_seq.sv
// rtl/plus_mult_seq.sv - unsigned multiplier built from one addition per clock
module plus_mult_seq
  import plus_mult_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] plus_in,
  input  logic [DATA_W-1:0] count_in,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy,
  output logic              done
);

  state_t              r_state;
  logic [DATA_W-1:0]   r_op;
  logic [DATA_W-1:0]   r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    w_op_ext;

  assign w_op_ext = {{(ACC_W-DATA_W){1'b0}}, r_op};

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_op    <= plus_in;
            r_cnt   <= count_in;
            r_acc   <= '0;
            r_state <= (count_in == '0) ? ST_DONE : ST_ADD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ADD: begin
          // abort has priority over both the addition and any start request
          if (abort) begin
            r_acc   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_acc <= r_acc + w_op_ext;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == {{(DATA_W-1){1'b0}}, 1'b1}) begin
              r_state <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign acc_out = r_acc;
  assign busy    = (r_state == ST_ADD);
  assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_plus_mult_seq.sv
// tb/tb_plus_mult_seq.sv - directed self-checking bench for plus_mult_seq
module tb_plus_mult_seq;

  logic       clk;
  logic       clear_n;
  logic       start;
  logic       abort;
  logic [3:0] plus_in;
  logic [3:0] count_in;
  logic [7:0] acc_out;
  logic       busy;
  logic       done;

  int n_pass  = 0;
  int n_total = 0;

  plus_mult_seq dut (
    .clk      (clk),
    .clear_n  (clear_n),
    .start    (start),
    .abort    (abort),
    .plus_in  (plus_in),
    .count_in (count_in),
    .acc_out  (acc_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Launch p*c, scramble the operand inputs after the start edge, count busy cycles
  task automatic do_op(input string tag, input logic [3:0] p, input logic [3:0] c,
                       input int exp_busy, input logic [7:0] exp_acc);
    int n;
    plus_in  = p;
    count_in = c;
    start    = 1'b1;
    step();
    start    = 1'b0;
    plus_in  = ~p;
    count_in = ~c;
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
    check({tag, "_busy_cycles"}, n, exp_busy);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_acc"}, acc_out, exp_acc);
    step();
    check({tag, "_done_one_cycle"}, done, 1'b0);
    check({tag, "_acc_held"}, acc_out, exp_acc);
  endtask

  initial begin
    clear_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    plus_in  = '0;
    count_in = '0;
    step();
    check("rst_acc", acc_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    clear_n = 1'b1;
    step();

    do_op("op3x5", 4'd3, 4'd5, 5, 8'd15);
    do_op("op9x0", 4'd9, 4'd0, 0, 8'd0);
    do_op("op15x15", 4'd15, 4'd15, 15, 8'd225);

    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle_acc", acc_out, 225);
    check("abort_idle_busy", busy, 0);

    // start during ADD ignored, then back-to-back start held through DONE
    plus_in = 4'd3; count_in = 4'd4; start = 1'b1;
    step();
    start = 1'b0;
    check("ign_c1_acc", acc_out, 0);
    step();
    check("ign_c2_acc", acc_out, 3);
    plus_in = 4'd7; count_in = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    check("ign_acc", acc_out, 6);
    check("ign_busy", busy, 1);
    step();
    check("ign_c4_acc", acc_out, 9);
    step();
    check("ign_done", done, 1);
    check("ign_result", acc_out, 12);
    plus_in = 4'd2; count_in = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_acc_clr", acc_out, 0);
    step();
    check("b2b_c2_acc", acc_out, 2);
    step();
    check("b2b_done", done, 1);
    check("b2b_result", acc_out, 4);
    step();

    // abort in ADD cycle 3
    plus_in = 4'd5; count_in = 4'd6; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("abt_c3_acc", acc_out, 10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abt_busy", busy, 0);
    check("abt_done", done, 0);
    check("abt_acc", acc_out, 0);
    step();
    check("abt_no_done", done, 0);

    // abort together with start in ADD: abort wins
    plus_in = 4'd5; count_in = 4'd6; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    abort = 1'b1; start = 1'b1; plus_in = 4'd1; count_in = 4'd1;
    step();
    abort = 1'b0; start = 1'b0;
    check("abs_busy", busy, 0);
    check("abs_done", done, 0);
    check("abs_acc", acc_out, 0);
    step();
    check("abs_no_done", done, 0);
    check("abs_still_idle", busy, 0);

    // asynchronous clear mid-ADD
    plus_in = 4'd6; count_in = 4'd7; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("clr_pre_acc", acc_out, 12);
    #2 clear_n = 1'b0;
    #1;
    check("clr_acc", acc_out, 0);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    step();
    clear_n = 1'b1;
    step();
    do_op("op2x3", 4'd2, 4'd3, 3, 8'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/plus_mult_seq.md
PLUS_MULT_SEQ -- requirements
Module: plus_mult_seq

Interface
REQ-001 Parameter: DATA_W, default 4, operand width; matches the Plus register width.
REQ-002 Parameter: ACC_W, default 2*DATA_W, accumulator/result width; fixed at 2*DATA_W, never overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clear_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled on clk edge, accepted only in IDLE or DONE.
REQ-006 abort  input  1  synchronous cancel of a running operation.
REQ-007 plus_in  input  DATA_W  multiplicand, driven by the Plus register output.
REQ-008 count_in  input  DATA_W  multiplier, number of repeated additions.
REQ-009 acc_out  output  ACC_W  product / accumulator value, registered.
REQ-010 busy  output  1  high while in ADD.
REQ-011 done  output  1  high for exactly one cycle while in DONE.

Function
REQ-012 Block SHALL compute acc_out = plus_in * count_in (unsigned) by repeated addition, one addition per cycle.
REQ-013 FSM states SHALL be IDLE, ADD, DONE; busy = (state==ADD), done = (state==DONE), both decoded from registered state.
REQ-014 On an accepted start edge, block SHALL capture plus_in into op_q, capture count_in into cnt_q, and clear acc to 0 on that same edge.
REQ-015 Accepted start with count_in != 0 SHALL go to ADD; with count_in == 0 SHALL go directly to DONE with acc_out = 0.
REQ-016 In ADD each edge SHALL do acc += zero-extended op_q, cnt_q -= 1; when cnt_q == 1 before the edge, next state SHALL be DONE.
REQ-017 Latency: for count N >= 1, done SHALL be high in the cycle following the (N+1)th edge counted from and including the start edge, i.e. N ADD cycles, then one DONE cycle.
REQ-018 Addition SHALL be ACC_W wide; overflow is impossible (max (2^DATA_W-1)^2 < 2^ACC_W), and no carry flag exists.
REQ-019 DONE SHALL last one cycle, then go to IDLE unless start is high, in which case a new operation SHALL be accepted (back-to-back, per REQ-014/015).
REQ-020 acc_out SHALL hold the final product through DONE and IDLE until the next accepted start.
REQ-021 start while in ADD SHALL be ignored, with no effect on op_q, cnt_q or acc.
REQ-022 plus_in/count_in changes after the start edge SHALL have no effect on the running operation.
REQ-023 abort high in ADD SHALL return to IDLE on that edge with acc cleared to 0 and no done pulse; abort in IDLE/DONE SHALL be ignored.
REQ-024 abort and start both high in the same cycle: in ADD abort SHALL win; in IDLE/DONE start SHALL be accepted.

Reset
REQ-025 clear_n low SHALL asynchronously force state = IDLE, acc_out = 0, op_q = 0, cnt_q = 0, busy = 0, done = 0, including mid-operation.
REQ-026 After clear_n deasserts, the first accepted start SHALL behave identically to post-power-up.

Structure
REQ-027 Shared package SHALL hold the state enum (IDLE/ADD/DONE), DATA_W default and derived ACC_W constant.
REQ-028 Single module; no sub-module, because the counter and accumulator are inline registers.

Verification
REQ-029 plus_in=3, count_in=5, start 1 cycle -> busy 5 cycles, then done 1 cycle, acc_out=15 held afterwards.
REQ-030 count_in=0, plus_in=9, start -> done in the cycle after the start edge, busy never high, acc_out=0.
REQ-031 plus_in=15, count_in=15 -> acc_out=225 after 15 ADD cycles, with no wrap.
REQ-032 Start 3x4, pulse start again in ADD cycle 2 with plus_in=7 -> ignored, result 12; then start held high through DONE with 2x2 -> back-to-back result 4.
REQ-033 Start 5x6, abort in ADD cycle 3 -> IDLE next cycle, acc_out=0, no done pulse; same scenario with abort+start together -> abort wins.
REQ-034 Start 6x7, drop clear_n mid-ADD (between edges) -> immediate IDLE, all outputs 0; after release, 2x3 -> 6.
